// File: rtl/exe_divider.sv
// rtl/exe_divider.sv - iterative RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring
module exe_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FAST,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_nx;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quot;
  logic [XLEN-1:0]   r_div;
  logic [XLEN-1:0]   r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_rem;
  logic              r_neg_q;
  logic              r_neg_r;

  // Operand decode in IDLE: op_i[0]=0 marks the signed ops (DIV, REM).
  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;

  assign w_signed   = ~op_i[0];
  assign w_a_neg    = w_signed & rs1_i[XLEN-1];
  assign w_b_neg    = w_signed & rs2_i[XLEN-1];
  // Negating MIN_NEG yields MIN_NEG, which is the correct unsigned magnitude.
  assign w_a_abs    = w_a_neg ? (~rs1_i + XLEN'(1)) : rs1_i;
  assign w_b_abs    = w_b_neg ? (~rs2_i + XLEN'(1)) : rs2_i;
  assign w_div0     = (rs2_i == '0);
  assign w_ovf      = w_signed && (rs1_i == MIN_NEG) && (rs2_i == '1);
  assign w_fast     = w_div0 | w_ovf;
  assign w_fast_res = w_div0 ? (op_i[1] ? rs1_i : '1)
                             : (op_i[1] ? '0 : MIN_NEG);

  // One restoring step: the borrow of the XLEN+1-bit trial decides the quotient bit.
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_trial;
  logic [XLEN-1:0]   w_rem_nx;
  logic [XLEN-1:0]   w_quot_nx;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic [XLEN-1:0]   w_calc_res;
  logic              w_last;

  assign w_rem_sh   = {r_rem, r_quot[XLEN-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_div};
  assign w_rem_nx   = w_trial[XLEN] ? w_rem_sh[XLEN-1:0] : w_trial[XLEN-1:0];
  assign w_quot_nx  = {r_quot[XLEN-2:0], ~w_trial[XLEN]};
  assign w_q_fix    = r_neg_q ? (~w_quot_nx + XLEN'(1)) : w_quot_nx;
  assign w_r_fix    = r_neg_r ? (~w_rem_nx + XLEN'(1)) : w_rem_nx;
  assign w_calc_res = r_is_rem ? w_r_fix : w_q_fix;
  assign w_last     = (r_cnt == CNT_W'(1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and status outputs; kill overrides every non-IDLE transition.
  always_comb begin
    w_state_nx = r_state;
    busy_o     = 1'b0;
    valid_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && !kill_i) begin
          w_state_nx = w_fast ? S_FAST : S_CALC;
        end
      end
      S_CALC: begin
        busy_o = 1'b1;
        if (kill_i) begin
          w_state_nx = S_IDLE;
        end else if (w_last) begin
          w_state_nx = S_DONE;
        end
      end
      S_FAST: begin
        busy_o     = 1'b1;
        w_state_nx = kill_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        busy_o     = 1'b1;
        valid_o    = ~kill_i;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, and register the sign-corrected result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rem    <= '0;
      r_quot   <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i && !kill_i) begin
            r_is_rem <= op_i[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div    <= w_b_abs;
            r_rem    <= '0;
            r_cnt    <= CNT_W'(XLEN);
            // The fast path parks its answer in the quotient register.
            r_quot   <= w_fast ? w_fast_res : w_a_abs;
          end
        end
        S_CALC: begin
          if (!kill_i) begin
            r_rem  <= w_rem_nx;
            r_quot <= w_quot_nx;
            r_cnt  <= r_cnt - CNT_W'(1);
            if (w_last) begin
              r_result <= w_calc_res;
            end
          end
        end
        S_FAST: begin
          if (!kill_i) begin
            r_result <= r_quot;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result_o = r_result;

endmodule

// File: doc/exe_divider.md
Name: exe_divider

Overview:
- Iterative RV32M divide/remainder unit in the execute stage. Computes DIV, DIVU, REM and REMU.
- Its result joins the ALU result path into the memory stage. It holds the pipeline through busy_o while it iterates.
- Implementation is radix-2 restoring division, one quotient bit per cycle.
- Divide-by-zero and signed overflow are resolved on a fast path.

Parameters:
- XLEN, 32, operand and result width
- CNT_W, $clog2(XLEN)+1, width of the iteration counter

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  synchronous active-low reset
- start_i  input  1  launch a divide op; sampled in IDLE only
- op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_i  input  XLEN  dividend
- rs2_i  input  XLEN  divisor
- kill_i  input  1  flush from the hazard unit; aborts the in-flight op
- busy_o  output  1  op in flight; the hazard unit turns this into an execute stall
- valid_o  output  1  one-cycle pulse; result_o is valid
- result_o  output  XLEN  quotient or remainder, per the latched op

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset state: FSM goes to IDLE. busy_o=0, valid_o=0, result_o=0, and all internal registers are cleared.
- Reset mid-operation: the op is dropped, no valid_o is produced, and the unit is in IDLE on the next cycle.

FSM states:
- IDLE
  - start_i=1 latches op_i, rs1_i and rs2_i.
  - Signed ops (DIV, REM) latch sign flags, then take the absolute value of each operand.
  - If rs2_i==0, or the op is signed with rs1_i==0x80000000 and rs2_i==0xFFFFFFFF: go to FAST.
  - Otherwise: go to CALC with counter=XLEN, remainder accumulator=0, quotient register=|dividend|.
- CALC, one iteration per cycle:
  - Shift {rem,quot} left by 1.
  - Trial = rem_shifted - |divisor|, computed as an XLEN+1-bit subtract.
  - If the trial is non-negative: rem=trial and quot[0]=1. Otherwise quot[0]=0.
  - Decrement the counter. When the counter reaches 1 this cycle, go to DONE.
- FAST: load the special result directly into result_o, then go to DONE.
  - Divide by zero: quotient = all ones (0xFFFFFFFF) for DIV and DIVU; remainder = rs1 unmodified.
  - Signed overflow: quotient = 0x80000000, remainder = 0.
- DONE
  - Sign fix-up for CALC results on signed ops: quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
  - result_o is registered. valid_o=1 for exactly this cycle. Next state is IDLE.
  - start_i is ignored in DONE.

Timing and status:
- busy_o=1 in CALC, FAST and DONE. It is 0 in IDLE only.
- Latency, with start accepted at cycle 0:
  - normal path: valid_o at cycle XLEN+1 (33)
  - fast path: valid_o at cycle 2

Control rules:
- start_i outside IDLE is ignored. There is no queuing.
- kill_i=1 in any non-IDLE state forces IDLE next cycle with valid_o=0. It takes priority over the DONE transition.
- kill_i together with start_i in IDLE: start is ignored.
- result_o holds its last value after valid_o drops. Consumers use it only while valid_o=1.

Arithmetic:
- All magnitudes are unsigned XLEN-bit. The trial subtract is XLEN+1 bits, and its borrow decides the quotient bit.
- Negation is two's complement at XLEN bits.
- |0x80000000| is treated as the unsigned value 0x80000000 (no overflow in the magnitude).

Test Plan:
- DIVU 100/7 -> result_o=0x0000000E, valid_o at cycle 33, busy_o high cycles 1..33. REMU with the same operands -> 0x00000002.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). REM 7 / 0xFFFFFFFE -> 0x00000001.
- DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 0x00000005. Both give valid_o at cycle 2 through FAST.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0x00000000. Both give valid_o at cycle 2.
- kill_i asserted at cycle 10 of DIVU -> busy_o=0 at cycle 11, and valid_o never pulses for that op. A following DIVU 9/3 then returns 0x00000003.
- rst_ni low at cycle 5 of an op -> busy_o=0, valid_o=0, result_o=0 on the next edge. start_i held high during DONE is not accepted (exactly one valid_o pulse).
